atconv_mem_host: RTL
====================

Name: atconv_mem_host

Overview:
- Synthesizable host/memory responder for the ATCONV accelerator; it is the slave end of ATCONV's ready/busy, image-read and layer-memory interfaces.
- Holds the 4096x13 input image ROM (loaded via a side port), the Layer0 RAM (4096x13) and the Layer1 RAM (1024x13).
- Arms ATCONV and serves its reads and writes. After busy falls, it streams both layers out on a valid/ready dump port.
- Replaces the behavioural memory models for FPGA/emulation runs.

Parameters:
- IMG_WORDS, 4096, image and Layer0 depth
- L1_WORDS, 1024, Layer1 depth
- DW, 13, data width
- AW, 12, address width
- TIMEOUT_CYC, 10000000, run cycles before abort

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- ld_valid  in  1  image load strobe
- ld_addr  in  AW  image load address
- ld_data  in  DW  image load data
- start  in  1  one-cycle pulse; begins a run
- ready  out  1  to ATCONV
- busy  in  1  from ATCONV
- iaddr  in  AW  image read address
- idata  out  DW  image read data
- cwr  in  1  layer write enable
- caddr_wr  in  AW  layer write address
- cdata_wr  in  DW  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  AW  layer read address
- cdata_rd  out  DW  layer read data
- csel  in  1  0=Layer0, 1=Layer1
- dump_valid  out  1  dump word valid
- dump_ready  in  1  dump consumer accept
- dump_sel  out  1  layer of current dump word
- dump_addr  out  AW  address of current dump word
- dump_data  out  DW  dump word
- done  out  1  run finished, dump complete
- written0  out  1  Layer0 received at least one write this run
- written1  out  1  Layer1 received at least one write this run
- timeout  out  1  run aborted

Behaviour:
- Reset (reset==0 at a rising edge) drives these values:
  - FSM goes to IDLE.
  - ready, dump_valid, done, written0, written1, timeout are 0.
  - idata, cdata_rd, dump_data, dump_addr are 0; dump_sel is 0.
  - Memory arrays are not cleared.
- Reset mid-run or mid-dump aborts immediately to IDLE.
- FSM states: IDLE, ARM, RUN, DUMP, DONE, ABORT.
- IDLE:
  - ld_valid writes ld_data to image[ld_addr] on the clock edge.
  - start goes to ARM.
  - Loads in any other state are ignored.
- ARM:
  - ready=1.
  - Clears written0/1 and the timeout counter on entry.
  - busy==1 goes to RUN; ready deasserts the cycle after busy is first sampled high.
- RUN:
  - idata = image[iaddr], combinational (same-cycle), when busy==1 and ready==0; otherwise 0.
  - cwr==1 writes cdata_wr into the RAM selected by csel at the clock edge, and sets written0 or written1.
  - A Layer1 write with caddr_wr>=L1_WORDS is dropped.
  - While crd==1, cdata_rd = mem_csel[caddr_rd] combinationally, and the value is captured into a holding register at the edge.
  - While crd==0, cdata_rd holds the last captured value.
  - A Layer1 read out of range returns 0.
  - Simultaneous cwr and crd to the same address and layer: the read returns the old data; the write lands at the edge.
  - busy==0 goes to DUMP if written0|written1, else to DONE.
  - Timeout counter reaching TIMEOUT_CYC goes to ABORT.
- DUMP:
  - Streams Layer0 addresses 0..4095 (dump_sel=0), then Layer1 0..1023 (dump_sel=1).
  - First dump_valid is asserted 1 cycle after DUMP entry (registered RAM read).
  - A word transfers when dump_valid&dump_ready.
  - While stalled, dump_data, dump_addr and dump_sel stay stable.
  - Transfers can be back-to-back, with no bubbles while dump_ready stays high.
  - After the transfer of Layer1 address 1023, go to DONE.
- DONE: done=1 and held; start goes to ARM (the image is retained).
- ABORT: timeout=1 and held; start goes to ARM.
- start in ARM, RUN or DUMP is ignored.
- ATCONV bus inputs are ignored outside RUN.

Optional Feature:
- Macro: ATCONV_HOST_CYCLE_CNT_EN.
- With the macro: adds output run_cycles[30:0].
  - Cleared on ARM entry.
  - Increments every cycle in RUN.
  - Frozen afterwards; saturates at all-ones.
- Without the macro: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Package atconv_host_pkg holds:
  - FSM state enum;
  - IMG_WORDS and L1_WORDS constants;
  - the DW/AW defaults.
- One natural sub-module, atconv_host_ram: a single-port-write / async-plus-sync-read RAM parameterised by depth. It is instantiated three times (image, Layer0, Layer1).

Test Plan:
- Image serving: load image[i]=i&0x1FFF, start, model ATCONV raises busy and reads iaddr=5 → idata=5 in the same cycle; ready falls 1 cycle after busy.
- Layer write/read: cwr csel=0 addr 100 data 0x0ABC, then crd csel=0 addr 100 → cdata_rd=0x0ABC; with crd=0 the next cycle, cdata_rd still 0x0ABC; written0=1, written1=0.
- Collision: Layer1 addr 7 holds 0x0011. Same-cycle cwr/crd, csel=1, addr 7, cdata_wr=0x0022 → cdata_rd=0x0011; a later read returns 0x0022.
- Out-of-range: csel=1 write addr 2000 → Layer1 is unchanged and the dump shows no change; a read at addr 2000 returns 0.
- Dump with backpressure: busy falls with written1=1, dump_ready toggles 1/0 each cycle → exactly 5120 transfers in address order, values match writes, data stable during stalls, then done=1.
- Abort: TIMEOUT_CYC=50 and busy held high → timeout=1 at cycle 50 of RUN. Reset pulse mid-DUMP → IDLE, all outputs 0, image contents preserved on the next run.

Source files
------------

// File: rtl/atconv_host_pkg.sv
// Shared types and sizing for the ATCONV host/memory responder.
package atconv_host_pkg;

  localparam int unsigned IMG_WORDS = 4096;
  localparam int unsigned L1_WORDS  = 1024;
  localparam int unsigned DEF_DW    = 13;
  localparam int unsigned DEF_AW    = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DUMP,
    ST_DONE,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/atconv_host_ram.sv
// Single-write-port RAM with an async read and an enable-captured sync read
// sharing one read address; out-of-range writes are dropped, reads return 0.
module atconv_host_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 13,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  input  logic          re,
  input  logic          sync_mode,
  output logic [DW-1:0] rdata
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_async;
  logic [DW-1:0] rdata_q;
  logic          w_in;
  logic          r_in;

  assign w_in        = 32'(waddr) < DEPTH;
  assign r_in        = 32'(raddr) < DEPTH;
  assign rdata_async = r_in ? mem[raddr[IW-1:0]] : '0;
  assign rdata       = sync_mode ? rdata_q : rdata_async;

  always_ff @(posedge clk) begin
    if (we && w_in) mem[waddr[IW-1:0]] <= wdata;
    if (re) rdata_q <= rdata_async;
  end

endmodule

// File: rtl/atconv_mem_host.sv
// Host/memory responder for ATCONV: image ROM, Layer0/Layer1 RAMs, run control
// and post-run layer dump. Optional run cycle counter: ATCONV_HOST_CYCLE_CNT_EN.
module atconv_mem_host
  import atconv_host_pkg::*;
#(
  parameter int unsigned IMG_WORDS   = atconv_host_pkg::IMG_WORDS,
  parameter int unsigned L1_WORDS    = atconv_host_pkg::L1_WORDS,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned TIMEOUT_CYC = 10000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          csel,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          dump_sel,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          done,
  output logic          written0,
  output logic          written1,
  output logic          timeout
`ifdef ATCONV_HOST_CYCLE_CNT_EN
  ,
  output logic [30:0]   run_cycles
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] cd_hold;
  logic          ptr_sel;
  logic [AW-1:0] ptr_addr;
  logic          issued_all;

  logic          run;
  logic          in_dump;
  logic          dump_adv;
  logic          dump_issue;
  logic [DW-1:0] img_rdata;
  logic [DW-1:0] l0_rdata;
  logic [DW-1:0] l1_rdata;
  logic [AW-1:0] layer_raddr;
  logic [DW-1:0] rd_live;

  assign run         = (state == ST_RUN);
  assign in_dump     = (state == ST_DUMP);
  assign dump_adv    = !dump_valid || dump_ready;
  assign dump_issue  = in_dump && dump_adv && !issued_all;
  assign layer_raddr = in_dump ? ptr_addr : caddr_rd;
  assign rd_live     = csel ? l1_rdata : l0_rdata;

  assign idata     = (run && busy && !ready) ? img_rdata : '0;
  assign cdata_rd  = (run && crd) ? rd_live : cd_hold;
  // Dump word comes straight from the selected RAM's captured read register.
  assign dump_data = dump_valid ? (dump_sel ? l1_rdata : l0_rdata) : '0;

  atconv_host_ram #(.DEPTH(IMG_WORDS), .DW(DW), .AW(AW)) u_img (
    .clk       (clk),
    .we        ((state == ST_IDLE) && ld_valid),
    .waddr     (ld_addr),
    .wdata     (ld_data),
    .raddr     (iaddr),
    .re        (1'b0),
    .sync_mode (1'b0),
    .rdata     (img_rdata)
  );

  atconv_host_ram #(.DEPTH(IMG_WORDS), .DW(DW), .AW(AW)) u_l0 (
    .clk       (clk),
    .we        (run && cwr && !csel),
    .waddr     (caddr_wr),
    .wdata     (cdata_wr),
    .raddr     (layer_raddr),
    .re        (dump_issue && !ptr_sel),
    .sync_mode (in_dump),
    .rdata     (l0_rdata)
  );

  atconv_host_ram #(.DEPTH(L1_WORDS), .DW(DW), .AW(AW)) u_l1 (
    .clk       (clk),
    .we        (run && cwr && csel),
    .waddr     (caddr_wr),
    .wdata     (cdata_wr),
    .raddr     (layer_raddr),
    .re        (dump_issue && ptr_sel),
    .sync_mode (in_dump),
    .rdata     (l1_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ready      <= 1'b0;
      dump_valid <= 1'b0;
      dump_sel   <= 1'b0;
      dump_addr  <= '0;
      done       <= 1'b0;
      written0   <= 1'b0;
      written1   <= 1'b0;
      timeout    <= 1'b0;
      tcnt       <= '0;
      cd_hold    <= '0;
      ptr_sel    <= 1'b0;
      ptr_addr   <= '0;
      issued_all <= 1'b0;
`ifdef ATCONV_HOST_CYCLE_CNT_EN
      run_cycles <= '0;
`endif
    end else begin
      if (run && crd) cd_hold <= rd_live;
      case (state)
        ST_IDLE, ST_DONE, ST_ABORT: begin
          if (start) begin
            state    <= ST_ARM;
            ready    <= 1'b1;
            done     <= 1'b0;
            timeout  <= 1'b0;
            written0 <= 1'b0;
            written1 <= 1'b0;
            tcnt     <= '0;
`ifdef ATCONV_HOST_CYCLE_CNT_EN
            run_cycles <= '0;
`endif
          end
        end
        ST_ARM: begin
          if (busy) begin
            state <= ST_RUN;
            ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cwr && !csel) written0 <= 1'b1;
          if (cwr && csel)  written1 <= 1'b1;
          tcnt <= tcnt + TW'(1);
`ifdef ATCONV_HOST_CYCLE_CNT_EN
          if (run_cycles != '1) run_cycles <= run_cycles + 31'd1;
`endif
          if (!busy) begin
            if (written0 || written1 || cwr) begin
              state      <= ST_DUMP;
              ptr_sel    <= 1'b0;
              ptr_addr   <= '0;
              issued_all <= 1'b0;
              dump_valid <= 1'b0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state   <= ST_ABORT;
            timeout <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (dump_adv) begin
            if (!issued_all) begin
              dump_valid <= 1'b1;
              dump_sel   <= ptr_sel;
              dump_addr  <= ptr_addr;
              if (!ptr_sel && ptr_addr == AW'(IMG_WORDS - 1)) begin
                ptr_sel  <= 1'b1;
                ptr_addr <= '0;
              end else if (ptr_sel && ptr_addr == AW'(L1_WORDS - 1)) begin
                issued_all <= 1'b1;
              end else begin
                ptr_addr <= ptr_addr + AW'(1);
              end
            end else begin
              // Last Layer1 word just transferred.
              dump_valid <= 1'b0;
              state      <= ST_DONE;
              done       <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
